// File: rtl/ps2_command_sender_if.sv
`default_nettype none
// ============================================================================
// Module      : ps2_command_sender_if
// Description : Command handshake between a PS/2 command client and the
//               host-to-device PS/2 transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface ps2_command_sender_if;
    logic       send_command;
    logic [7:0] the_command;
    logic       busy;
    logic       command_was_sent;
    logic       error_communication_timed_out;
    logic       error_no_ack;

    modport master (
        output send_command,
        output the_command,
        input  busy,
        input  command_was_sent,
        input  error_communication_timed_out,
        input  error_no_ack
    );

    modport slave (
        input  send_command,
        input  the_command,
        output busy,
        output command_was_sent,
        output error_communication_timed_out,
        output error_no_ack
    );
endinterface
`default_nettype wire

// File: rtl/ps2_command_sender.sv
`default_nettype none
// ============================================================================
// Module      : ps2_command_sender
// Description : PS/2 host-to-device transmitter: request-to-send, 11-bit
//               frame on the device clock, ACK check, timeout reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_command_sender #(
    parameter int CLOCK_FREQUENCY = 50000000
) (
    input  wire logic           Clock,
    input  wire logic           reset,
    ps2_command_sender_if.slave cmd,
    inout  wire                 PS2_CLK,
    inout  wire                 PS2_DAT
);

    localparam int c_INHIBIT_CYCLES = CLOCK_FREQUENCY / 10000;
    localparam int c_START_TIMEOUT  = CLOCK_FREQUENCY * 3 / 200;
    localparam int c_XFER_TIMEOUT   = CLOCK_FREQUENCY / 500;
    localparam int c_CNT_W          = $clog2(c_START_TIMEOUT) + 1;

    localparam logic [c_CNT_W-1:0] c_INHIBIT_LOAD = c_CNT_W'(c_INHIBIT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_START_LOAD   = c_CNT_W'(c_START_TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_XFER_LOAD    = c_CNT_W'(c_XFER_TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE      = c_CNT_W'(1);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_INHIBIT    = 4'd1,
        S_START      = 4'd2,
        S_WAIT_FIRST = 4'd3,
        S_DATA       = 4'd4,
        S_ACK_WAIT   = 4'd5,
        S_RELEASE    = 4'd6,
        S_DONE       = 4'd7,
        S_ERR_TO     = 4'd8,
        S_ERR_NACK   = 4'd9
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_CNT_W-1:0]   w_count_next;
    logic [c_CNT_W-1:0]   w_count_dec;
    logic                 w_expired;
    logic [10:0]          r_shift;
    logic [10:0]          w_shift_next;
    logic [3:0]           r_bit;
    logic [3:0]           w_bit_next;
    logic [1:0]           r_clk_sync;
    logic [1:0]           r_dat_sync;
    logic                 r_clk_prev;
    logic                 r_clk_fall;
    logic                 r_sent;
    logic                 r_err_to;
    logic                 r_err_nack;
    logic                 w_clk_low;
    logic                 w_dat_low;
    logic                 w_parity;

    // Frame bit 0 is the start bit; each device falling edge shifts the next bit out.
    assign w_parity    = ~^cmd.the_command;
    assign w_expired   = (r_count <= c_CNT_ONE);
    assign w_count_dec = (r_count == '0) ? '0 : r_count - c_CNT_ONE;

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_clk_prev <= 1'b1;
            r_clk_fall <= 1'b0;
        end else begin
            r_clk_sync <= {r_clk_sync[0], PS2_CLK};
            r_dat_sync <= {r_dat_sync[0], PS2_DAT};
            r_clk_prev <= r_clk_sync[1];
            r_clk_fall <= r_clk_prev & ~r_clk_sync[1];
        end
    end

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_shift    <= '0;
            r_bit      <= '0;
            r_sent     <= 1'b0;
            r_err_to   <= 1'b0;
            r_err_nack <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_count    <= w_count_next;
            r_shift    <= w_shift_next;
            r_bit      <= w_bit_next;
            r_sent     <= (r_state == S_DONE);
            r_err_to   <= (r_state == S_ERR_TO);
            r_err_nack <= (r_state == S_ERR_NACK);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_shift_next = r_shift;
        w_bit_next   = r_bit;
        w_clk_low    = 1'b0;
        w_dat_low    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd.send_command) begin
                    w_shift_next = {1'b1, w_parity, cmd.the_command, 1'b0};
                    w_count_next = c_INHIBIT_LOAD;
                    w_bit_next   = 4'd0;
                    w_state_next = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                w_clk_low    = 1'b1;
                w_count_next = w_count_dec;
                if (w_expired) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                w_clk_low    = 1'b1;
                w_dat_low    = 1'b1;
                w_count_next = c_START_LOAD;
                w_state_next = S_WAIT_FIRST;
            end
            S_WAIT_FIRST: begin
                w_dat_low    = ~r_shift[0];
                w_count_next = w_count_dec;
                if (r_clk_fall) begin
                    w_shift_next = {1'b1, r_shift[10:1]};
                    w_bit_next   = 4'd1;
                    w_count_next = c_XFER_LOAD;
                    w_state_next = S_DATA;
                end else if (w_expired) begin
                    w_state_next = S_ERR_TO;
                end
            end
            S_DATA: begin
                w_dat_low    = ~r_shift[0];
                w_count_next = w_count_dec;
                if (w_expired) begin
                    w_state_next = S_ERR_TO;
                end else if (r_clk_fall) begin
                    w_shift_next = {1'b1, r_shift[10:1]};
                    w_bit_next   = r_bit + 4'd1;
                    // The edge that exposes the stop bit ends the data phase.
                    if (r_bit == 4'd9) begin
                        w_state_next = S_ACK_WAIT;
                    end
                end
            end
            S_ACK_WAIT: begin
                w_count_next = w_count_dec;
                if (w_expired) begin
                    w_state_next = S_ERR_TO;
                end else if (r_clk_fall) begin
                    w_state_next = r_dat_sync[1] ? S_ERR_NACK : S_RELEASE;
                end
            end
            S_RELEASE: begin
                w_count_next = w_count_dec;
                if (w_expired) begin
                    w_state_next = S_ERR_TO;
                end else if (r_clk_sync[1] && r_dat_sync[1]) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE, S_ERR_TO, S_ERR_NACK: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign cmd.busy                          = (r_state != S_IDLE);
    assign cmd.command_was_sent              = r_sent;
    assign cmd.error_communication_timed_out = r_err_to;
    assign cmd.error_no_ack                  = r_err_nack;

    assign PS2_CLK = w_clk_low ? 1'b0 : 1'bz;
    assign PS2_DAT = w_dat_low ? 1'b0 : 1'bz;

endmodule
`default_nettype wire

// File: tb/tb_ps2_command_sender.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_command_sender
// Description : Self-checking bench with a PS/2 device model and scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_command_sender;

    localparam int CLOCK_FREQUENCY = 1000000;
    localparam int INH  = CLOCK_FREQUENCY / 10000;
    localparam int ST   = CLOCK_FREQUENCY * 3 / 200;
    localparam int XF   = CLOCK_FREQUENCY / 500;
    localparam int HALF = CLOCK_FREQUENCY / 25000;   // 12.5 kHz device clock

    localparam logic [2:0] OUT_SENT = 3'b001;
    localparam logic [2:0] OUT_TO   = 3'b010;
    localparam logic [2:0] OUT_NACK = 3'b100;

    logic Clock = 1'b0;
    logic reset = 1'b0;
    bit   dev_clk_low = 1'b0;
    bit   dev_dat_low = 1'b0;
    wire  ps2_clk;
    wire  ps2_dat;

    int n_checks   = 0;
    int n_failures = 0;
    int cyc        = 0;
    int pulse_cyc  = 0;
    int release_cyc = 0;
    int fall1_cyc  = 0;

    logic       exp_bits[$];
    logic [2:0] exp_out[$];

    ps2_command_sender_if cmd_if ();

    pullup (ps2_clk);
    pullup (ps2_dat);
    assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

    ps2_command_sender #(.CLOCK_FREQUENCY(CLOCK_FREQUENCY)) dut (
        .Clock   (Clock),
        .reset   (reset),
        .cmd     (cmd_if.slave),
        .PS2_CLK (ps2_clk),
        .PS2_DAT (ps2_dat)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_failures++;
            $display("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic check_window(input string tag, input int lat, input int lo, input int hi);
        check_value(tag, (lat >= lo && lat <= hi) ? lo : lat, lo);
    endtask

    // Scoreboard: every outcome pulse is matched against the queued expectation.
    always @(negedge Clock) begin
        if (reset && (cmd_if.command_was_sent || cmd_if.error_communication_timed_out ||
                      cmd_if.error_no_ack)) begin
            pulse_cyc = cyc;
            check_value("busy_at_pulse", cmd_if.busy, 0);
            if (exp_out.size() == 0) begin
                check_value("spurious_pulse",
                            {cmd_if.error_no_ack, cmd_if.error_communication_timed_out,
                             cmd_if.command_was_sent}, 0);
            end else begin
                check_value("outcome",
                            {cmd_if.error_no_ack, cmd_if.error_communication_timed_out,
                             cmd_if.command_was_sent}, exp_out.pop_front());
            end
        end
    end

    task automatic send_and_request(input logic [7:0] b, input logic [2:0] outcome);
        int n;
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            exp_bits.push_back(b[i]);
            if (b[i]) ones++;
        end
        exp_bits.push_back((ones % 2) == 0);
        exp_bits.push_back(1'b1);
        exp_out.push_back(outcome);
        @(negedge Clock);
        cmd_if.send_command = 1'b1;
        cmd_if.the_command  = b;
        @(negedge Clock);
        cmd_if.send_command = 1'b0;
        check_value("busy_on_accept", cmd_if.busy, 1);
        check_value("clk_low_on_accept", ps2_clk, 0);
        n = 0;
        while (ps2_clk === 1'b0 && ps2_dat === 1'b1 && n < INH * 4) begin
            n++;
            @(negedge Clock);
        end
        check_value("inhibit_len", n, INH);
        n = 0;
        while (ps2_clk === 1'b0 && ps2_dat === 1'b0 && n < 10) begin
            n++;
            @(negedge Clock);
        end
        check_value("start_len", n, 1);
        check_value("clk_released", ps2_clk, 1);
        check_value("start_bit", ps2_dat, 0);
        release_cyc = cyc;
    endtask

    task automatic device_clock(input int n_edges, input bit ack, input bit inject);
        for (int k = 1; k <= n_edges; k++) begin
            repeat (HALF / 2) @(negedge Clock);
            if (k == 11) dev_dat_low = ack;
            repeat (HALF / 2) @(negedge Clock);
            dev_clk_low = 1'b1;
            if (k == 1) fall1_cyc = cyc;
            if (k == 3 && inject) begin
                @(negedge Clock);
                cmd_if.send_command = 1'b1;
                cmd_if.the_command  = 8'h55;
                @(negedge Clock);
                cmd_if.send_command = 1'b0;
                repeat (HALF - 2) @(negedge Clock);
            end else begin
                repeat (HALF) @(negedge Clock);
            end
            dev_clk_low = 1'b0;
            if (k <= 10) begin
                if (exp_bits.size() == 0) check_value("bit_queue_empty", 1, 0);
                else check_value($sformatf("bit%0d", k), ps2_dat, exp_bits.pop_front());
            end
        end
        if (n_edges == 11) begin
            repeat (HALF) @(negedge Clock);
            dev_dat_low = 1'b0;
        end
    endtask

    task automatic wait_outcome(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (exp_out.size() != 0 && n < max_cycles) begin
            @(negedge Clock);
            n++;
        end
        if (exp_out.size() != 0) begin
            check_value(tag, exp_out.size(), 0);
            exp_out.delete();
        end
        @(negedge Clock);
        check_value({tag, "_clk_idle"}, ps2_clk, 1);
        check_value({tag, "_dat_idle"}, ps2_dat, 1);
        check_value({tag, "_busy_idle"}, cmd_if.busy, 0);
    endtask

    task automatic full_frame(input logic [7:0] b, input bit ack, input string tag);
        send_and_request(b, ack ? OUT_SENT : OUT_NACK);
        device_clock(11, ack, 1'b0);
        wait_outcome(tag, 3000);
        exp_bits.delete();
    endtask

    initial begin
        int n;
        bit clk_seen_low;
        cmd_if.send_command = 1'b0;
        cmd_if.the_command  = 8'h00;
        repeat (3) @(negedge Clock);
        check_value("rst_busy", cmd_if.busy, 0);
        check_value("rst_pulses", {cmd_if.error_no_ack, cmd_if.error_communication_timed_out,
                                   cmd_if.command_was_sent}, 0);
        check_value("rst_clk", ps2_clk, 1);
        check_value("rst_dat", ps2_dat, 1);
        reset = 1'b1;
        repeat (3) @(negedge Clock);

        // 0xED with a second send injected while busy; only one frame may appear.
        send_and_request(8'hED, OUT_SENT);
        device_clock(11, 1'b1, 1'b1);
        wait_outcome("ed_frame", 3000);
        exp_bits.delete();
        clk_seen_low = 1'b0;
        repeat (300) begin
            @(negedge Clock);
            if (ps2_clk !== 1'b1 || cmd_if.busy) clk_seen_low = 1'b1;
        end
        check_value("ignored_while_busy", clk_seen_low, 0);

        full_frame(8'hF4, 1'b1, "f4_frame");
        full_frame(8'h00, 1'b1, "00_frame");
        full_frame(8'hFF, 1'b0, "nack_frame");

        // Device never clocks.
        send_and_request(8'hF4, OUT_TO);
        wait_outcome("start_timeout", ST + 100);
        check_window("start_timeout_latency", pulse_cyc - release_cyc, ST, ST + 2);
        exp_bits.delete();

        // Device stops after four bits.
        send_and_request(8'hA5, OUT_TO);
        device_clock(4, 1'b0, 1'b0);
        wait_outcome("xfer_timeout", XF + 100);
        check_window("xfer_timeout_latency", pulse_cyc - fall1_cyc, XF, XF + 6);
        exp_bits.delete();

        // Reset mid-DATA.
        send_and_request(8'h3C, OUT_SENT);
        device_clock(4, 1'b0, 1'b0);
        @(negedge Clock);
        reset = 1'b0;
        #1;
        check_value("midrst_clk", ps2_clk, 1);
        check_value("midrst_dat", ps2_dat, 1);
        check_value("midrst_busy", cmd_if.busy, 0);
        check_value("midrst_pulses", {cmd_if.error_no_ack, cmd_if.error_communication_timed_out,
                                      cmd_if.command_was_sent}, 0);
        exp_out.delete();
        exp_bits.delete();
        repeat (3) @(negedge Clock);
        reset = 1'b1;
        repeat (3) @(negedge Clock);
        full_frame(8'h00, 1'b1, "after_reset_frame");

        n = 0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/ps2_command_sender.md
# ps2_command_sender

Host-to-device PS/2 transmitter. It is the outbound counterpart of the keyboard receive path in the dino game top level. It takes a command byte (e.g. 0xFF reset, 0xED set-LEDs, 0xF4 enable) and performs the full PS/2 host request-to-send sequence on the shared open-drain `PS2_CLK`/`PS2_DAT` lines, then reports success or a timeout. While it owns the bus it asserts `busy`, and the receive path ignores line activity for that time.

## Interface
- `CLOCK_FREQUENCY`, default 50000000: frequency of `Clock` in Hz. All timeouts are derived from it with integer division:
  - `INHIBIT_CYCLES = CLOCK_FREQUENCY/10000` (100 µs)
  - `START_TIMEOUT = CLOCK_FREQUENCY*3/200` (15 ms)
  - `XFER_TIMEOUT = CLOCK_FREQUENCY/500` (2 ms)

Ports:
- `Clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `send_command`  in  1  one-cycle strobe; accepted only in IDLE.
- `the_command`  in  8  command byte, captured on the accepting cycle.
- `PS2_CLK`  inout  1  open-drain: driven 0 or high-Z, never driven 1.
- `PS2_DAT`  inout  1  open-drain: driven 0 or high-Z, never driven 1.
- `busy`  out  1  high while a transfer is in progress.
- `command_was_sent`  out  1  one-cycle pulse on ACK received.
- `error_communication_timed_out`  out  1  one-cycle pulse on any timeout.
- `error_no_ack`  out  1  one-cycle pulse when the device does not ACK (`PS2_DAT` high on the 11th falling edge).

## Operation
- `PS2_CLK` and `PS2_DAT` are each synchronised through 2 flops. A falling edge is the sync output going 1→0, detected 3 `Clock` cycles after the pin transition.
- Frame: start(0), d0..d7 LSB first, odd parity (the bit that makes the count of 1s over data+parity odd), stop (line released = 1), then the device ACK.
- IDLE: both lines high-Z, `busy`=0. On `send_command`=1: capture `the_command` into the shift register, compute parity, load the counter with `INHIBIT_CYCLES`, go to INHIBIT.
- INHIBIT: drive `PS2_CLK`=0 for `INHIBIT_CYCLES` cycles with `PS2_DAT` high-Z, then go to START.
- START: drive `PS2_DAT`=0 with `PS2_CLK` still low for 1 cycle. Then release `PS2_CLK` while keeping `PS2_DAT`=0, load the counter with `START_TIMEOUT`, go to WAIT_FIRST.
- WAIT_FIRST: on the first falling edge, drive d0 and load `XFER_TIMEOUT`, go to DATA. If the counter expires first, go to ERR_TO.
- DATA: on each subsequent falling edge, present the next bit: d1..d7, then parity, then release `PS2_DAT` (stop). After the stop bit is released, go to ACK_WAIT.
- ACK_WAIT: on the next falling edge (the 11th overall), sample the synced `PS2_DAT`. If 0, go to RELEASE. If 1, go to ERR_NACK.
- RELEASE: wait until both synced lines are 1, then go to DONE.
- DONE, ERR_TO, ERR_NACK: single-cycle states that return to IDLE.
- `XFER_TIMEOUT` runs continuously from the first falling edge through RELEASE and is not reloaded per bit. Expiry in DATA, ACK_WAIT or RELEASE goes to ERR_TO.
- In ERR_TO and ERR_NACK both lines are released immediately.
- Counters are down-counters sized `$clog2(START_TIMEOUT)+1` bits. Expiry is the count reaching 0.

## Timing
- Reset: all outputs 0, both lines high-Z, state IDLE, shift register 0. Assertion mid-transfer releases both lines asynchronously with no pulse.
- Accept: `busy`=1 from the cycle after the `send_command` sample. `PS2_CLK` is driven low in that same cycle.
- Output pulses are registered and assert the cycle after DONE/ERR_*. `busy` deasserts in that same cycle.
- `send_command` in that same cycle or later is accepted. `send_command` while `busy`=1 is ignored and not queued.
- Line drive changes take effect 1 cycle after the falling edge is detected, i.e. 4 `Clock` cycles after the pin edge.
- A glitch shorter than 2 cycles on `PS2_CLK` need not be filtered. Only edges seen at the sync output count.

## Test plan
- Send 0xED with a device model clocking at 12.5 kHz and ACKing. Required:
  - `PS2_CLK` held low exactly 5000 cycles (at 50 MHz), then bits 0,1,0,1,1,0,1,1,1, parity 1, stop 1.
  - `command_was_sent` pulses once and `busy` falls in the same cycle.
- Send 0xF4 → parity bit 0; send 0x00 → parity bit 1. Check each serial bit against the model's sample on the rising edge.
- Device never clocks after the request → `error_communication_timed_out` pulses 750000 cycles after the clock is released. Lines high-Z, `busy`=0.
- Device stops clocking after 4 bits → timeout pulse 100000 cycles after the first falling edge, lines released.
- Device leaves `PS2_DAT` high on the 11th edge → `error_no_ack` pulse, and no `command_was_sent`.
- Second `send_command` while busy is ignored (one frame only). `reset`=0 during DATA → lines high-Z immediately, all outputs 0, and the next send works normally.
